// File: rtl/gray_step_decoder.sv
// gray_step_decoder: synchronises an asynchronous Gray-coded position word,
// converts it to binary, classifies each change as +1 / -1 / illegal and
// keeps a wrapping signed position count with error reporting.
module gray_step_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned POS_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     g_in,
    input  logic                 clr,
    output logic [WIDTH-1:0]     bin_out,
    output logic [POS_WIDTH-1:0] pos,
    output logic                 step_valid,
    output logic                 step_dir,
    output logic                 err,
    output logic                 err_sticky
);

    // Cycles after reset release until bin_out reflects a freshly sampled g_in
    localparam int unsigned INIT_CYC = SYNC_STAGES + 1;
    localparam int unsigned CNT_W    = $clog2(INIT_CYC + 1);

    localparam logic [WIDTH-1:0] D_ZERO = '0;
    localparam logic [WIDTH-1:0] D_UP   = WIDTH'(1);
    localparam logic [WIDTH-1:0] D_DOWN = '1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   init_cnt;
    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   g_s;
    logic [WIDTH-1:0]   b_c;
    logic [WIDTH-1:0]   b_prev;
    logic [WIDTH-1:0]   b_last;
    logic [WIDTH-1:0]   diff_c;

    // Multi-flop synchroniser for the asynchronous Gray word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= g_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign g_s = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        b_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            b_c[i] = ^(g_s >> i);
        end
    end

    // Registered binary value, also the value the classifier works on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_out <= '0;
        end else begin
            bin_out <= b_c;
        end
    end

    // Modular distance from the accepted baseline
    assign diff_c = bin_out - b_prev;

    // Step classifier FSM with position counter and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            init_cnt   <= '0;
            b_prev     <= '0;
            b_last     <= '0;
            pos        <= '0;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            step_valid <= 1'b0;
            err        <= 1'b0;
            b_last     <= bin_out;

            case (state)
                // Baseline tracks bin_out until the pipeline holds post-reset samples
                ST_INIT: begin
                    b_prev <= bin_out;
                    if (init_cnt == CNT_W'(INIT_CYC)) begin
                        state <= ST_TRACK;
                    end else begin
                        init_cnt <= init_cnt + CNT_W'(1);
                    end
                end

                ST_TRACK: begin
                    if (diff_c == D_ZERO) begin
                        state <= ST_TRACK;
                    end else if (diff_c == D_UP) begin
                        step_valid <= 1'b1;
                        step_dir   <= 1'b1;
                        pos        <= pos + POS_WIDTH'(1);
                        b_prev     <= bin_out;
                    end else if (diff_c == D_DOWN) begin
                        step_valid <= 1'b1;
                        step_dir   <= 1'b0;
                        pos        <= pos - POS_WIDTH'(1);
                        b_prev     <= bin_out;
                    end else begin
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        state      <= ST_RESYNC;
                    end
                end

                // Accept a new baseline once the code is stable for two cycles
                ST_RESYNC: begin
                    if (bin_out == b_last) begin
                        b_prev <= bin_out;
                        state  <= ST_TRACK;
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase

            // Clear overrides any concurrent count or sticky update
            if (clr) begin
                pos        <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gray_step_decoder.sv
// Testbench for gray_step_decoder: directed scenarios plus random code walks
// checked against a position-level reference model.
module tb_gray_step_decoder;

    localparam int unsigned W    = 4;
    localparam int unsigned HOLD = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] g_in;
    logic       clr;

    logic [3:0] bin_out;
    logic [7:0] pos;
    logic       step_valid, step_dir, err, err_sticky;

    logic [3:0] bin4;
    logic [3:0] pos4;
    logic       sv4, sd4, e4, es4;

    int checks = 0;
    int errors = 0;

    // Reference model state: accepted binary baseline, position, sticky error
    logic [3:0] m_base;
    logic [7:0] m_pos;
    logic       m_sticky;

    // Pulse totals seen by the monitor
    int tot_up = 0;
    int tot_dn = 0;
    int tot_err = 0;

    gray_step_decoder #(.WIDTH(4), .POS_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .g_in(g_in), .clr(clr),
        .bin_out(bin_out), .pos(pos), .step_valid(step_valid),
        .step_dir(step_dir), .err(err), .err_sticky(err_sticky)
    );

    gray_step_decoder #(.WIDTH(4), .POS_WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .g_in(g_in), .clr(clr),
        .bin_out(bin4), .pos(pos4), .step_valid(sv4),
        .step_dir(sd4), .err(e4), .err_sticky(es4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_valid && step_dir)  tot_up  = tot_up + 1;
        if (step_valid && !step_dir) tot_dn  = tot_dn + 1;
        if (err)                     tot_err = tot_err + 1;
    end

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a new code, let it settle, then compare against the model
    task automatic step_to(input logic [3:0] nb, input string tag);
        logic [3:0] d;
        int eu, ed, ee, su, sd, se;
        d  = nb - m_base;
        eu = 0; ed = 0; ee = 0;
        if (d == 4'd1) begin
            eu = 1; m_pos = m_pos + 8'd1;
        end else if (d == 4'd15) begin
            ed = 1; m_pos = m_pos - 8'd1;
        end else if (d != 4'd0) begin
            ee = 1; m_sticky = 1'b1;
        end
        m_base = nb;
        su = tot_up; sd = tot_dn; se = tot_err;
        g_in = to_gray(nb);
        repeat (HOLD) @(posedge clk);
        #1;
        chk({tag, ".bin"},    32'(bin_out),    32'(nb));
        chk({tag, ".pos"},    32'(pos),        32'(m_pos));
        chk({tag, ".pos4"},   32'(pos4),       32'(m_pos[3:0]));
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
        chk({tag, ".up"},     32'(tot_up - su),  32'(eu));
        chk({tag, ".dn"},     32'(tot_dn - sd),  32'(ed));
        chk({tag, ".err"},    32'(tot_err - se), 32'(ee));
    endtask

    // Legal step with exact-latency check, optionally with clr on the pulse edge
    task automatic step_timed(input logic [3:0] nb, input logic do_clr, input string tag);
        logic [3:0] d;
        logic       up;
        d  = nb - m_base;
        up = (d == 4'd1);
        m_pos  = up ? m_pos + 8'd1 : m_pos - 8'd1;
        m_base = nb;
        @(posedge clk);
        #1 g_in = to_gray(nb);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".early_sv"}, 32'(step_valid), 32'd0);
        if (do_clr) begin
            clr = 1'b1;
            m_pos = 8'd0;
            m_sticky = 1'b0;
        end
        @(posedge clk);
        #1 clr = 1'b0;
        chk({tag, ".sv"},     32'(step_valid), 32'd1);
        chk({tag, ".dir"},    32'(step_dir),   32'(up));
        chk({tag, ".err"},    32'(err),        32'd0);
        chk({tag, ".pos"},    32'(pos),        32'(m_pos));
        chk({tag, ".pos4"},   32'(pos4),       32'(m_pos[3:0]));
        chk({tag, ".sticky"}, 32'(err_sticky), 32'(m_sticky));
        @(posedge clk);
        #1 chk({tag, ".sv_off"}, 32'(step_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] nb;
        int r;

        // Reset with g_in = 0
        rst_n = 1'b0; g_in = 4'b0000; clr = 1'b0;
        m_base = 4'd0; m_pos = 8'd0; m_sticky = 1'b0;
        #3;
        chk("rst.bin",    32'(bin_out),    32'd0);
        chk("rst.pos",    32'(pos),        32'd0);
        chk("rst.sv",     32'(step_valid), 32'd0);
        chk("rst.err",    32'(err),        32'd0);
        chk("rst.sticky", 32'(err_sticky), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("init.pos",  32'(pos),     32'd0);
        chk("init.errs", 32'(tot_err), 32'd0);

        // Full Gray walk upward
        for (int i = 1; i < 16; i++) step_to(4'(i), "walk");
        chk("walk.pos15", 32'(pos), 32'd15);
        chk("walk.noerr", 32'(tot_err), 32'd0);

        // Code wrap in both directions with exact latency
        step_timed(4'd0, 1'b0, "wrap_up");
        step_timed(4'd15, 1'b0, "wrap_dn");
        step_to(4'd0, "wrap_up2");

        // Illegal jump, resync on stable code, then a legal step
        step_to(4'd2, "jump");
        step_to(4'd2, "hold");
        step_to(4'd3, "after_jump");

        // clr coincident with an up step while err_sticky is set
        step_timed(4'd4, 1'b1, "clr_step");

        // Counter wrap below zero and back (4-bit instance wraps at 16)
        step_to(4'd3, "pos_under");
        chk("pos_under.ff",  32'(pos),  32'hff);
        chk("pos_under.f4",  32'(pos4), 32'hf);
        step_to(4'd4, "pos_over");
        chk("pos_over.p4",   32'(pos4), 32'h0);

        // Random code sequence
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      nb = m_base + 4'd1;
            else if (r < 7) nb = m_base - 4'd1;
            else if (r == 7) nb = m_base;
            else            nb = 4'($urandom_range(0, 15));
            step_to(nb, "rand");
        end

        // Asynchronous reset mid-walk, release on 0110
        g_in = to_gray(m_base + 4'd1);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.bin",    32'(bin_out),    32'd0);
        chk("arst.pos",    32'(pos),        32'd0);
        chk("arst.sv",     32'(step_valid), 32'd0);
        chk("arst.err",    32'(err),        32'd0);
        chk("arst.sticky", 32'(err_sticky), 32'd0);
        g_in = 4'b0110;
        m_base = 4'd4; m_pos = 8'd0; m_sticky = 1'b0;
        repeat (2) @(negedge clk);
        begin
            int su, sd, se;
            su = tot_up; sd = tot_dn; se = tot_err;
            rst_n = 1'b1;
            repeat (8) @(posedge clk);
            #1;
            chk("rel.bin",    32'(bin_out),    32'd4);
            chk("rel.pos",    32'(pos),        32'd0);
            chk("rel.steps",  32'(tot_up - su + tot_dn - sd), 32'd0);
            chk("rel.err",    32'(tot_err - se), 32'd0);
            chk("rel.sticky", 32'(err_sticky), 32'd0);
        end
        step_to(4'd5, "rel_up");
        step_to(4'd4, "rel_dn");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
